// File: rtl/sincronize_pkg.sv
// Shared defaults and sizing helper for the key synchronizer/debouncer.
// The counter is one bit wider than strictly needed so DEBOUNCE_CYCLES=1 still gets a legal width.
package sincronize_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 2;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency STAGES clocks; no flow control.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sincronize.sv
// Key synchronizer + debouncer emitting a one-clock pulse on each accepted press.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES clocks from first sample; no backpressure.
module sincronize
  import sincronize_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic key_press,
  output logic key_detect,
  input  logic rst
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  logic          db;
  logic          db_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_press),
    .q   (s)
  );

  // Any sample agreeing with db restarts qualification of a change.
  always_comb begin
    db_nxt  = db;
    cnt_nxt = '0;
    if (s != db) begin
      if (cnt == CNT_LAST) begin
        db_nxt = s;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db         <= 1'b0;
      cnt        <= '0;
      key_detect <= 1'b0;
    end else begin
      db         <= db_nxt;
      cnt        <= cnt_nxt;
      key_detect <= db_nxt & ~db;
    end
  end

  cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= CNT_LAST);

endmodule

// File: tb/tb_sincronize.sv
// Bench for sincronize: default instance plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=8 instance,
// directed timing scenarios followed by random key activity against a sample-history model.
module tb_sincronize;

  localparam int SA   = 2;
  localparam int DA   = 2;
  localparam int SB   = 3;
  localparam int DB   = 8;
  localparam int HMAX = 8192;

  logic clk;
  logic rst;
  logic key_a, key_b;
  logic kd_a, kd_b;

  int errors = 0;
  int checks = 0;
  int pulse_a = 0;
  int pulse_b = 0;

  sincronize dut_a (
    .clk        (clk),
    .key_press  (key_a),
    .key_detect (kd_a),
    .rst        (rst)
  );

  sincronize #(
    .SYNC_STAGES     (SB),
    .DEBOUNCE_CYCLES (DB)
  ) dut_b (
    .clk        (clk),
    .key_press  (key_b),
    .key_detect (kd_b),
    .rst        (rst)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: raw samples per edge since reset; s(k) = raw(k - stages);
  // db flips when the last D synchronized samples all disagree with it.
  bit raw_h [2][HMAX];
  int kidx  [2];
  bit mdb   [2];
  bit exp_kd[2];
  int m_k, m_d, m_st;
  bit m_flip;

  function automatic bit s_at(input int i, input int k);
    int st;
    st = (i == 0) ? SA : SB;
    if (k - st < 0) return 1'b0;
    return raw_h[i][(k - st) % HMAX];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        kidx[i]   = 0;
        mdb[i]    = 1'b0;
        exp_kd[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_k  = kidx[i];
        m_d  = (i == 0) ? DA : DB;
        raw_h[i][m_k % HMAX] = (i == 0) ? key_a : key_b;
        m_flip = (m_k + 1 >= m_d);
        for (int j = 0; j < m_d; j++) begin
          if (m_k - j >= 0 && s_at(i, m_k - j) == mdb[i]) m_flip = 1'b0;
        end
        exp_kd[i] = m_flip && !mdb[i];
        if (m_flip) mdb[i] = !mdb[i];
        kidx[i] = m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("kd_a_model", {31'd0, kd_a}, {31'd0, exp_kd[0]});
    check("kd_b_model", {31'd0, kd_b}, {31'd0, exp_kd[1]});
    if (kd_a) pulse_a++;
    if (kd_b) pulse_b++;
  end

  // Press on A at a negedge: pulse must appear exactly after the 4th edge, for one cycle.
  task automatic press_latency_a(input string tag);
    key_a = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_pre"}, {31'd0, kd_a}, 32'd0);
    @(negedge clk);
    check({tag, "_hit"}, {31'd0, kd_a}, 32'd1);
    @(negedge clk);
    check({tag, "_post"}, {31'd0, kd_a}, 32'd0);
    key_a = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  int base;

  initial begin
    rst   = 1'b0;
    key_a = 1'b0;
    key_b = 1'b0;

    // Basic press: rst released at 10 ns, key 35..65 ns
    #5;
    check("reset_kd_a", {31'd0, kd_a}, 32'd0);
    check("reset_kd_b", {31'd0, kd_b}, 32'd0);
    #5 rst = 1'b1;
    #25 key_a = 1'b1;
    #30;
    check("basic_e3", {31'd0, kd_a}, 32'd0);
    key_a = 1'b0;
    #10 check("basic_e4", {31'd0, kd_a}, 32'd1);
    #10 check("basic_e5", {31'd0, kd_a}, 32'd0);
    #180 check("basic_count", pulse_a, 32'd1);

    // Single-cycle glitch
    @(negedge clk);
    base = pulse_a;
    key_a = 1'b1;
    @(negedge clk);
    key_a = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch_db_mid", {31'd0, dut_a.db}, 32'd0);
    repeat (8) @(negedge clk);
    check("glitch_db", {31'd0, dut_a.db}, 32'd0);
    check("glitch_count", pulse_a - base, 32'd0);

    // Long hold, release, re-press
    base = pulse_a;
    key_a = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_count", pulse_a - base, 32'd1);
    key_a = 1'b0;
    repeat (5) @(negedge clk);
    key_a = 1'b1;
    repeat (10) @(negedge clk);
    key_a = 1'b0;
    repeat (10) @(negedge clk);
    check("repress_count", pulse_a - base, 32'd2);

    // Reset during qualification aborts the press
    base = pulse_a;
    key_a = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst_mid_kd", {31'd0, kd_a}, 32'd0);
    key_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_count", pulse_a - base, 32'd0);
    press_latency_a("after_rst");

    // Reset during the pulse clears it immediately
    key_a = 1'b1;
    repeat (4) @(negedge clk);
    check("pulse_before_rst", {31'd0, kd_a}, 32'd1);
    #2 rst = 1'b0;
    #1 check("rst_pulse_kd", {31'd0, kd_a}, 32'd0);
    key_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Key held through reset release counts as a new press
    base = pulse_a;
    rst = 1'b0;
    key_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    press_latency_a("held_at_release");
    check("held_count", pulse_a - base, 32'd1);

    // Wide instance: 7 samples rejected, 8 accepted with latency 11
    base = pulse_b;
    key_b = 1'b1;
    repeat (7) @(negedge clk);
    key_b = 1'b0;
    repeat (20) @(negedge clk);
    check("b_short_count", pulse_b - base, 32'd0);
    key_b = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 8)  key_b = 1'b0;
      if (c == 10) check("b_lat_pre", {31'd0, kd_b}, 32'd0);
      if (c == 11) check("b_lat_hit", {31'd0, kd_b}, 32'd1);
      if (c == 12) check("b_lat_post", {31'd0, kd_b}, 32'd0);
    end
    repeat (5) @(negedge clk);
    check("b_count", pulse_b - base, 32'd1);

    // Random key activity with occasional resets
    for (int n = 0; n < 120; n++) begin
      key_a = 1'($urandom_range(0, 1));
      key_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    key_a = 1'b0;
    key_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sincronize.md
SINCRONIZE -- requirements
Module: sincronize

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flip-flops; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2, consecutive synchronized samples needed to accept a level change; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 key_press  input  1  raw asynchronous key level; 1 means pressed.
REQ-006 key_detect  output  1  registered one-clock pulse on each accepted press (rising edge of the debounced key).
REQ-007 Port order SHALL be clk, key_press, key_detect, rst.

Function
REQ-008 key_press SHALL pass through a SYNC_STAGES-deep flip-flop chain; s denotes the last stage output.
REQ-009 A debounced level db and a counter cnt of width clog2(DEBOUNCE_CYCLES)+1 SHALL be kept.
REQ-010 Each clock: if s equals db, cnt SHALL clear to 0.
REQ-011 Each clock: if s differs from db and cnt equals DEBOUNCE_CYCLES-1, db SHALL take s and cnt SHALL clear.
REQ-012 Each clock: if s differs from db and cnt is below DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-013 key_detect SHALL be 1 for exactly the clock following the edge where db changes 0->1; otherwise 0.
REQ-014 db changing 1->0 (release) SHALL NOT assert key_detect.
REQ-015 Latency with defaults: key_press high at sample edge E1 -> key_detect high after edge E4, low after E5.
REQ-016 A high glitch shorter than DEBOUNCE_CYCLES consecutive synchronized samples SHALL produce no pulse and SHALL leave db unchanged.
REQ-017 A key held high indefinitely SHALL produce exactly one pulse; a new pulse requires an accepted release first.
REQ-018 cnt SHALL never exceed DEBOUNCE_CYCLES-1, so no wrap-around occurs.
REQ-019 The output SHALL be driven directly by a flip-flop, with no combinational path from key_press.

Reset
REQ-020 While rst=0: all synchronizer stages, db, cnt and key_detect SHALL be 0 immediately, independent of clk.
REQ-021 Reset asserted mid-debounce or mid-pulse SHALL abort it; no pulse SHALL be produced for that press after release of reset unless it is re-qualified.
REQ-022 A key already held at reset release SHALL be treated as a new press: one pulse after the REQ-015 latency.

Structure
REQ-023 Package sincronize_pkg SHALL hold default constants SYNC_STAGES_DEF=2 and DEBOUNCE_CYCLES_DEF=2, plus the counter-width function.
REQ-024 Sub-module sync_chain (parameter STAGES, ports clk, rst, d, q) SHALL implement the synchronizer; debounce and edge logic live in sincronize.

Verification
REQ-025 Clock period 10 ns; rst=0 until 10 ns; key_press 0->1 at 35 ns, 1->0 at 65 ns -> exactly one key_detect pulse, 1 cycle wide, asserted after the 4th rising edge sampling key_press=1; then 0 through 265 ns.
REQ-026 One-cycle high glitch on key_press with DEBOUNCE_CYCLES=2 -> key_detect stays 0 and db stays 0.
REQ-027 key_press held high 50 cycles -> exactly one pulse; release 5 cycles, press again -> second single pulse.
REQ-028 rst driven low two cycles after key_press rises (before the pulse) -> key_detect 0 immediately and no pulse for that press; a press after reset release behaves per REQ-025.
REQ-029 key_press high while rst=0, then reset released -> one pulse 4 edges after release.
REQ-030 DEBOUNCE_CYCLES=8, SYNC_STAGES=3 -> press of 7 synchronized cycles gives no pulse; press of 8 gives one pulse at latency SYNC_STAGES+DEBOUNCE_CYCLES edges.
